// File: rtl/truth_table_sweeper_if.sv
// Stimulus/result bundle between the sweeper and the block under test.
// The sweeper takes the slave side; the environment drives start and f_in.
interface truth_table_sweeper_if;
  logic        start;
  logic        f_in;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] tt;
  logic [4:0]  mism_cnt;
  logic [3:0]  first_err;

  modport slave (
    input  start, f_in,
    output abcd, busy, done, pass, tt, mism_cnt, first_err
  );

  modport master (
    output start, f_in,
    input  abcd, busy, done, pass, tt, mism_cnt, first_err
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks all 16 {A,B,C,D} vectors through a 4-input function block, captures F
// into a truth table and grades it against EXPECTED.
module truth_table_sweeper #(
  parameter logic [15:0] EXPECTED = 16'h0DD0,
  parameter int unsigned SETTLE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  truth_table_sweeper_if.slave        bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  state_t      state, state_nx;
  logic [3:0]  idx, cnt;
  logic [15:0] tt;
  logic        busy, done, pass;
  logic [4:0]  mism;
  logic [3:0]  ferr;
  logic        accept, sample, last;
  logic [15:0] diff;
  logic [4:0]  pc;
  logic [3:0]  lo;

  assign accept = ((state == IDLE) || (state == DONE)) && bus.start;
  assign sample = (state == DRIVE) && (cnt == SETTLE_W);
  assign last   = sample && (idx == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nx = DRIVE;
      DRIVE:      if (last)      state_nx = CHECK;
      CHECK:                     state_nx = DONE;
      default:                   state_nx = IDLE;
    endcase
  end

  // Grading logic; only consumed during the single CHECK cycle.
  always_comb begin
    diff = tt ^ EXPECTED;
    pc   = '0;
    lo   = '0;
    for (int k = 15; k >= 0; k--) begin
      pc = pc + 5'(diff[k]);
      if (diff[k]) lo = 4'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      cnt  <= '0;
      tt   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      mism <= '0;
      ferr <= '0;
    end else if (accept) begin
      idx  <= '0;
      cnt  <= '0;
      tt   <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      pass <= 1'b0;
      mism <= '0;
      ferr <= '0;
    end else if (state == DRIVE) begin
      if (sample) begin
        tt[idx] <= bus.f_in;
        cnt     <= '0;
        // idx parks at 15 after the last sample so abcd holds 4'hF
        if (!last) idx <= idx + 4'd1;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end else if (state == CHECK) begin
      mism <= pc;
      ferr <= lo;
      pass <= (diff == 16'h0000);
      busy <= 1'b0;
      done <= 1'b1;
    end
  end

  assign bus.abcd      = idx;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.tt        = tt;
  assign bus.mism_cnt  = mism;
  assign bus.first_err = ferr;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (SETTLE=1 and SETTLE=0) fed by a
// behavioural function source, graded against a truth-table model.
module tb_truth_table_sweeper;
  localparam logic [15:0] EXP = 16'h0DD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st  = 1'b0;
  logic sel = 1'b0;
  int   mode = 0;
  logic [15:0] rnd_tbl = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if i0 ();
  truth_table_sweeper_if i1 ();

  truth_table_sweeper #(.EXPECTED(EXP), .SETTLE(1)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  truth_table_sweeper #(.EXPECTED(EXP), .SETTLE(0)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));

  // Source block: 0 true F, 1 stuck 0, 2 stuck 1, 3 inverted F, 4 random table
  function automatic logic fval(input logic [3:0] v, input int m, input logic [15:0] tbl);
    logic f;
    f = (v[3] ^ v[2]) & (v[1] | ~v[0]);
    case (m)
      0: fval = f;
      1: fval = 1'b0;
      2: fval = 1'b1;
      3: fval = ~f;
      default: fval = tbl[v];
    endcase
  endfunction

  always_comb begin
    i0.f_in  = fval(i0.abcd, mode, rnd_tbl);
    i1.f_in  = fval(i1.abcd, mode, rnd_tbl);
    i0.start = st & ~sel;
    i1.start = st & sel;
  end

  logic [3:0]  c_abcd, c_ferr;
  logic        c_busy, c_done, c_pass;
  logic [15:0] c_tt;
  logic [4:0]  c_mism;
  assign c_abcd = sel ? i1.abcd      : i0.abcd;
  assign c_busy = sel ? i1.busy      : i0.busy;
  assign c_done = sel ? i1.done      : i0.done;
  assign c_pass = sel ? i1.pass      : i0.pass;
  assign c_tt   = sel ? i1.tt        : i0.tt;
  assign c_mism = sel ? i1.mism_cnt  : i0.mism_cnt;
  assign c_ferr = sel ? i1.first_err : i0.first_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_abcd"}, 32'(c_abcd), 0);
    check({pfx, "_busy"}, 32'(c_busy), 0);
    check({pfx, "_done"}, 32'(c_done), 0);
    check({pfx, "_pass"}, 32'(c_pass), 0);
    check({pfx, "_tt"},   32'(c_tt),   0);
    check({pfx, "_mism"}, 32'(c_mism), 0);
    check({pfx, "_ferr"}, 32'(c_ferr), 0);
  endtask

  // One sweep on the selected unit; again = edge of a spurious start,
  // rst_at = edge at which reset aborts the sweep (-1 = none).
  task automatic sweep(input int s, input int again, input int rst_at);
    logic [15:0] et, d;
    int em, ef, n, dn;
    et = '0;
    for (int k = 0; k < 16; k++) et[k] = fval(4'(k), mode, rnd_tbl);
    d  = et ^ EXP;
    em = $countones(d);
    ef = 0;
    for (int k = 15; k >= 0; k--) if (d[k]) ef = k;
    dn = 16 * (s + 1) + 1;

    @(negedge clk); st = 1'b1;
    @(posedge clk);
    @(negedge clk); st = 1'b0;
    check("e0_busy", 32'(c_busy), 1);
    check("e0_done", 32'(c_done), 0);
    check("e0_tt",   32'(c_tt),   0);
    check("e0_mism", 32'(c_mism), 0);
    check("e0_pass", 32'(c_pass), 0);
    n = 0;
    while (!c_done) begin
      if (n > 300) begin
        check("done_timeout", 32'(n), 32'(dn));
        return;
      end
      check("run_busy", 32'(c_busy), 1);
      check("abcd", 32'(c_abcd), (n >= 16 * (s + 1)) ? 15 : n / (s + 1));
      st  = (n + 1 == again);
      rst = (n + 1 == rst_at);
      @(posedge clk);
      n++;
      @(negedge clk);
      st = 1'b0;
      if (n == rst_at) begin
        rst = 1'b0;
        check_zero("rst");
        @(posedge clk); @(negedge clk);
        check("idle_busy", 32'(c_busy), 0);
        check("idle_done", 32'(c_done), 0);
        return;
      end
    end
    check("done_edge", 32'(n), 32'(dn));
    check("busy",      32'(c_busy), 0);
    check("tt",        32'(c_tt),   32'(et));
    check("pass",      32'(c_pass), 32'(d == 16'h0));
    check("mism_cnt",  32'(c_mism), 32'(em));
    check("first_err", 32'(c_ferr), 32'(ef));
    check("abcd_end",  32'(c_abcd), 15);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold_done", 32'(c_done), 1);
    check("hold_tt",   32'(c_tt),   32'(et));
    check("hold_abcd", 32'(c_abcd), 15);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    mode = 0; sweep(1, -1, -1);
    mode = 1; sweep(1, -1, -1);
    mode = 2; sweep(1, -1, -1);
    mode = 3; sweep(1, -1, -1);
    mode = 4;
    for (int r = 0; r < 4; r++) begin
      rnd_tbl = 16'($urandom);
      sweep(1, -1, -1);
    end

    sel = 1'b1;
    mode = 0; sweep(0, 5, -1);
    mode = 2; sweep(0, 3, -1);

    sel = 1'b0;
    mode = 0; sweep(1, -1, 10);
    sweep(1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Upstream stimulus and downstream checker for the 4-input decoder-tree function block `main`: F = (AB' + A'B)(C + D').
- On `start`, drives all 16 input combinations {A,B,C,D} = 0..15 onto the function block, one combination at a time.
- Samples F for each combination and assembles a 16-bit truth table.
- Compares the table against an expected minterm mask and reports pass/fail, mismatch count and first failing minterm.
- Used for on-chip self-check of the combinational function stages.

Parameters:
- EXPECTED, 16'h0DD0, expected truth table; bit k = F at minterm k. Default is Σm(4,6,7,8,10,11).
- SETTLE, 1, extra cycles each vector is held before F is sampled; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  sweep request; sampled only in IDLE or DONE.
- f_in  input  1  F output of the function block under test.
- abcd  output  4  stimulus vector: abcd[3]=A, abcd[2]=B, abcd[1]=C, abcd[0]=D.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from completion until the next accepted start or rst.
- pass  output  1  valid when done=1; 1 iff captured table == EXPECTED.
- tt  output  16  captured truth table; bit k = sampled F for minterm k.
- mism_cnt  output  5  number of differing bits, 0..16; valid when done=1.
- first_err  output  4  lowest minterm index that differs; 0 when pass=1.

Behaviour:
- Reset (rst=1 at a clock edge) forces all of the following, regardless of state or start:
  - state=IDLE;
  - abcd=0, busy=0, done=0, pass=0, tt=0, mism_cnt=0, first_err=0;
  - internal vector index=0, settle counter=0.
- Reset mid-sweep aborts immediately. No partial result is retained.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE → DRIVE: at edge E0 where start=1.
  - At E0: index=0, settle counter=0, tt cleared, busy=1, done=0.
- DRIVE:
  - abcd = index, registered, changes only at clock edges.
  - The settle counter increments each edge.
  - When the counter equals SETTLE, the edge writes f_in into tt[index], resets the counter and increments index.
  - Vector k is therefore sampled at edge E0 + (k+1)(SETTLE+1).
  - Each vector is held exactly SETTLE+1 cycles.
  - The sample of index 15 moves to CHECK. abcd holds 4'hF and does not wrap to 0 until the next sweep.
- CHECK, one cycle. At its ending edge, computed from the complete tt:
  - diff = tt XOR EXPECTED;
  - mism_cnt = popcount(diff), 5-bit;
  - first_err = index of the lowest set bit of diff, or 0 if none;
  - pass = (diff == 0);
  - busy=0, done=1; go to DONE.
- Timing: done first reads 1 after edge E0 + 16(SETTLE+1) + 1. With SETTLE=1 that is 33 edges after E0.
- DONE:
  - Outputs hold steady.
  - start=1 behaves exactly as in IDLE: done drops and tt, mism_cnt, first_err and pass are cleared at E0.
- start while busy=1 is ignored. It neither restarts nor extends the sweep.
- start and rst high on the same edge: rst wins.
- Outputs are registered. There is no combinational path from f_in or start to any output.
- f_in is treated as synchronous to clk; no synchronizer is included.

Test Plan:
- Correct function block attached, SETTLE=1, start pulsed one cycle → after 33 edges: done=1, busy=0, tt=16'h0DD0, pass=1, mism_cnt=0, first_err=0. abcd steps 0..15, each value held 2 cycles.
- f_in tied 0 → tt=16'h0000, pass=0, mism_cnt=6, first_err=4.
- f_in tied 1 → tt=16'hFFFF, pass=0, mism_cnt=10, first_err=0.
- f_in = inverted F → tt=16'hF22F, mism_cnt=16, first_err=0, pass=0.
- SETTLE=0 → done after 17 edges, results as in the first test. start pulsed again at edge 5 of the sweep → ignored, completion edge unchanged.
- rst asserted at edge 10 of a sweep → next cycle all outputs 0, state IDLE. A fresh start then completes normally with pass=1.
